iserdes_frame_align: RTL

Frame-alignment controller that sits directly downstream of the ISERDES2 frame/data deserializer PHY in the `clkdiv` domain. It compares the deserialized frame-clock word against a known pattern and issues `bitslip` pulses back to the PHY until the word boundary is correct. It declares lock after a run of consecutive matches and re-aligns automatically after sustained loss. It also registers the PHY's 16-bit data word and qualifies it with a valid flag.

---
 rtl/iserdes_frame_align_pkg.sv | 31 +++
 rtl/iserdes_frame_align.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/iserdes_frame_align_pkg.sv
// rtl/iserdes_frame_align_pkg.sv - shared state encoding, width helper and frame pattern defaults
package iserdes_frame_align_pkg;

    // Alignment controller states
    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SLIP   = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } align_state_e;

    // Deserializer output modes used by the PHY wrapper
    typedef enum logic [0:0] {
        MODE_SDR = 1'b0,
        MODE_DDR = 1'b1
    } output_mode_e;

    // Frame-clock word expected from the PHY for each output mode
    function automatic logic [7:0] frame_pattern_for(input output_mode_e mode);
        return (mode == MODE_DDR) ? 8'hCC : 8'hF0;
    endfunction

    localparam logic [7:0] FRAME_PATTERN_DEFAULT = frame_pattern_for(MODE_SDR);

    // Bits needed to hold n distinct values, never less than one
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/iserdes_frame_align.sv
// rtl/iserdes_frame_align.sv - bitslip-driven frame alignment and data qualification for the ISERDES2 PHY
module iserdes_frame_align
    import iserdes_frame_align_pkg::*;
#(
    parameter int         DATA_WIDTH    = 8,
    parameter logic [7:0] FRAME_PATTERN = FRAME_PATTERN_DEFAULT,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         MATCH_COUNT   = 16,
    parameter int         LOSS_COUNT    = 4,
    parameter int         MAX_SLIPS     = 16
) (
    input  logic                                clkdiv,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic [DATA_WIDTH-1:0]               frame_in,
    input  logic [15:0]                         din,
    output logic                                bitslip,
    output logic                                locked,
    output logic                                fail,
    output logic [width_of(MAX_SLIPS+1)-1:0]    slip_count,
    output logic [15:0]                         dout,
    output logic                                dout_valid
);

    localparam int SW = width_of(SETTLE_CYCLES + 1);
    localparam int MW = width_of(MATCH_COUNT + 1);
    localparam int LW = width_of(LOSS_COUNT + 1);
    localparam int CW = width_of(MAX_SLIPS + 1);

    localparam logic [SW-1:0]         SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [MW-1:0]         MATCH_LAST  = MW'(MATCH_COUNT - 1);
    localparam logic [LW-1:0]         LOSS_LAST   = LW'(LOSS_COUNT - 1);
    localparam logic [CW-1:0]         SLIP_MAX    = CW'(MAX_SLIPS);
    localparam logic [DATA_WIDTH-1:0] PATTERN     = FRAME_PATTERN[DATA_WIDTH-1:0];

    align_state_e    state_q, state_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [MW-1:0]   match_q, match_d;
    logic [LW-1:0]   miss_q, miss_d;
    logic [CW-1:0]   slip_q, slip_d;
    logic            bitslip_q, bitslip_d;
    logic            locked_q, locked_d;
    logic            fail_q, fail_d;
    logic [15:0]     dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;
    logic            frame_match;

    assign frame_match = (frame_in == PATTERN);

    // Next-state and counter logic; start overrides every other transition
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        match_d  = match_q;
        miss_d   = miss_q;
        slip_d   = slip_q;

        if (start) begin
            state_d  = ST_WAIT;
            settle_d = '0;
            match_d  = '0;
            miss_d   = '0;
            slip_d   = '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (settle_q >= SETTLE_LAST) begin
                        state_d  = ST_CHECK;
                        settle_d = '0;
                        match_d  = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (frame_match) begin
                        match_d = match_q + 1'b1;
                        if (match_q >= MATCH_LAST) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                        end
                    end else if (slip_q >= SLIP_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_SLIP;
                    end
                end
                ST_SLIP: begin
                    if (slip_q != SLIP_MAX) begin
                        slip_d = slip_q + 1'b1;
                    end
                    settle_d = '0;
                    state_d  = ST_WAIT;
                end
                ST_LOCKED: begin
                    if (frame_match) begin
                        miss_d = '0;
                    end else if (miss_q >= LOSS_LAST) begin
                        // Loss may be transient: re-check after settling before slipping
                        state_d  = ST_WAIT;
                        miss_d   = '0;
                        slip_d   = '0;
                        settle_d = '0;
                    end else begin
                        miss_d = miss_q + 1'b1;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_WAIT;
                end
            endcase
        end

        bitslip_d    = (state_d == ST_SLIP);
        locked_d     = (state_d == ST_LOCKED);
        fail_d       = (state_d == ST_FAIL);
        dout_d       = din;
        dout_valid_d = (state_q == ST_LOCKED);
    end

    // State, counters and registered outputs; reset restarts alignment on release
    always_ff @(posedge clkdiv or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_WAIT;
            settle_q     <= '0;
            match_q      <= '0;
            miss_q       <= '0;
            slip_q       <= '0;
            bitslip_q    <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            match_q      <= match_d;
            miss_q       <= miss_d;
            slip_q       <= slip_d;
            bitslip_q    <= bitslip_d;
            locked_q     <= locked_d;
            fail_q       <= fail_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign bitslip    = bitslip_q;
    assign locked     = locked_q;
    assign fail       = fail_q;
    assign slip_count = slip_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule
